// File: rtl/ram_port_ctrl_if.sv
// Request/response and RAM-control bundle for ram_port_ctrl.
// master: requester plus RAM side (drives requests, rsp_ready and ram_q).
// slave: the controller (drives req_ready, the response and the RAM controls).
interface ram_port_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_q,
    input  req_ready, rsp_valid, rsp_data, ram_we, ram_addr, ram_d
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_q,
    output req_ready, rsp_valid, rsp_data, ram_we, ram_addr, ram_d
  );
endinterface

// File: rtl/ram_port_ctrl.sv
// Front end for a single-port synchronous RAM: valid/ready requests in, registered read responses out.
// Latency: writes land at the accept edge; read data is valid 2 cycles after the accept (one read outstanding).
// Backpressure: req_ready drops while a read is pending or an unpopped response is held; macro
// RAM_PORT_CTRL_INIT_EN adds a post-reset sweep writing INIT_VALUE to every word (busy_o high meanwhile).
module ram_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
`ifdef RAM_PORT_CTRL_INIT_EN
  ,
  // Only meaningful when the init sweep exists.
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
`endif
) (
  input  logic           clk_i,
  input  logic           reset_i,
  output logic           busy_o,
  ram_port_ctrl_if.slave bus
);

`ifdef RAM_PORT_CTRL_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;
  localparam state_t                RESET_STATE = ST_INIT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = {ADDR_WIDTH{1'b1}};
`else
  typedef enum logic {ST_IDLE = 1'b1} state_t;
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t                state_q;
  logic                  rd_pending_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [DATA_WIDTH-1:0] last_d_q;
  logic                  accept;
`ifdef RAM_PORT_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  in_init;

  assign in_init = (state_q == ST_INIT);
  assign busy_o  = in_init;
`else
  assign busy_o  = 1'b0;
`endif

  // A new request is refused while a read is in flight or a held response would be overwritten.
  assign bus.req_ready = !reset_i && (state_q == ST_IDLE) && !rd_pending_q &&
                         !(rsp_valid_q && !bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // RAM controls: sweep write, accepted request pass-through, or a harmless re-read of the last address.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = last_addr_q;
    bus.ram_d    = last_d_q;
`ifdef RAM_PORT_CTRL_INIT_EN
    if (in_init) begin
      bus.ram_we   = 1'b1;
      bus.ram_addr = init_addr_q;
      bus.ram_d    = INIT_VALUE;
    end else
`endif
    if (accept) begin
      bus.ram_we   = bus.req_we;
      bus.ram_addr = bus.req_addr;
      bus.ram_d    = bus.req_wdata;
    end
  end

  // Controller FSM: init sweep, request bookkeeping and response capture/pop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= RESET_STATE;
      rd_pending_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      last_addr_q  <= '0;
      last_d_q     <= '0;
`ifdef RAM_PORT_CTRL_INIT_EN
      init_addr_q  <= '0;
`endif
    end else begin
      unique case (state_q)
`ifdef RAM_PORT_CTRL_INIT_EN
        ST_INIT: begin
          // Single pass over the whole array; the counter is not reused afterwards.
          init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
          if (init_addr_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
          end
        end
`endif
        ST_IDLE: begin
          if (accept) begin
            last_addr_q <= bus.req_addr;
            last_d_q    <= bus.req_wdata;
            if (!bus.req_we) begin
              rd_pending_q <= 1'b1;
            end
          end
          // The RAM latched q at the accept edge; capture it now. Capture wins over a pop.
          if (rd_pending_q) begin
            rsp_data_q   <= bus.ram_q;
            rsp_valid_q  <= 1'b1;
            rd_pending_q <= 1'b0;
          end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= RESET_STATE;
      endcase
    end
  end

endmodule
